// File: rtl/klingon_digit_sequencer.sv
// Two-digit BCD step counter (00..99) with prescaler, synchronous load and wrap/error pulses.
// Define KLINGON_DOWN_COUNT_EN to add the 'up' port and down counting.
module klingon_digit_sequencer #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
`ifdef KLINGON_DOWN_COUNT_EN
  input  logic       up,
`endif
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic       tick,
  output logic       wrap,
  output logic       load_err
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic          count_up;
  logic [3:0]    lo_n, hi_n;
  logic          wrap_n;
  logic [3:0]    lo_ld, hi_ld;
  logic          ld_bad;

`ifdef KLINGON_DOWN_COUNT_EN
  assign count_up = up;
`else
  assign count_up = 1'b1;
`endif

  // Next digits for a step; >= / <= comparisons keep any stray state inside 0..9.
  always_comb begin
    lo_n   = digit_lo;
    hi_n   = digit_hi;
    wrap_n = 1'b0;
    if (count_up) begin
      if (digit_lo >= 4'd9) begin
        lo_n = '0;
        if (digit_hi >= 4'd9) begin
          hi_n   = '0;
          wrap_n = 1'b1;
        end else begin
          hi_n = digit_hi + 4'd1;
        end
      end else begin
        lo_n = digit_lo + 4'd1;
      end
    end else begin
      if (digit_lo == 4'd0 || digit_lo > 4'd9) begin
        lo_n = 4'd9;
        if (digit_hi == 4'd0 || digit_hi > 4'd9) begin
          hi_n   = 4'd9;
          wrap_n = 1'b1;
        end else begin
          hi_n = digit_hi - 4'd1;
        end
      end else begin
        lo_n = digit_lo - 4'd1;
      end
    end
  end

  always_comb begin
    lo_ld  = (load_val[3:0] > 4'd9) ? '0 : load_val[3:0];
    hi_ld  = (load_val[7:4] > 4'd9) ? '0 : load_val[7:4];
    ld_bad = (load_val[3:0] > 4'd9) || (load_val[7:4] > 4'd9);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre      <= '0;
      digit_lo <= '0;
      digit_hi <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // Load wins over a coincident step and restarts the prescale interval.
        pre      <= '0;
        digit_lo <= lo_ld;
        digit_hi <= hi_ld;
        load_err <= ld_bad;
      end else if (en) begin
        if (pre == PMAX) begin
          pre      <= '0;
          digit_lo <= lo_n;
          digit_hi <= hi_n;
          tick     <= 1'b1;
          wrap     <= wrap_n;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_klingon_digit_sequencer.sv
// Directed bench for klingon_digit_sequencer (PRESCALE=4) with a mod-100 reference model.
module tb_klingon_digit_sequencer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic       up;
  logic [3:0] digit_lo, digit_hi;
  logic       tick, wrap, load_err;

  int vectors = 0;
  int miscompares = 0;

  klingon_digit_sequencer #(.PRESCALE(P)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
`ifdef KLINGON_DOWN_COUNT_EN
    .up       (up),
`endif
    .digit_lo (digit_lo),
    .digit_hi (digit_hi),
    .tick     (tick),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the counter is a single integer 0..99 stepped with modular arithmetic.
  int m_val, m_pre, m_tick, m_wrap, m_err;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_err = 0;
    end else begin
      int lo, hi;
      m_tick = 0; m_wrap = 0; m_err = 0;
      if (load) begin
        lo = int'(load_val[3:0]);
        hi = int'(load_val[7:4]);
        m_err = (lo > 9 || hi > 9) ? 1 : 0;
        if (lo > 9) lo = 0;
        if (hi > 9) hi = 0;
        m_val = hi * 10 + lo;
        m_pre = 0;
      end else if (en) begin
        if (m_pre == P - 1) begin
          m_pre  = 0;
          m_tick = 1;
`ifdef KLINGON_DOWN_COUNT_EN
          if (!up) begin
            m_wrap = (m_val == 0) ? 1 : 0;
            m_val  = (m_val + 99) % 100;
          end else
`endif
          begin
            m_wrap = (m_val == 99) ? 1 : 0;
            m_val  = (m_val + 1) % 100;
          end
        end else begin
          m_pre++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("mdl_lo",   int'(digit_lo), m_val % 10);
    chk("mdl_hi",   int'(digit_hi), m_val / 10);
    chk("mdl_tick", int'(tick),     m_tick);
    chk("mdl_wrap", int'(wrap),     m_wrap);
    chk("mdl_err",  int'(load_err), m_err);
  end

  task automatic chk_out(input string name, input int hi, input int lo,
                         input int tk, input int wr, input int er);
    chk({name, "_hi"},   int'(digit_hi), hi);
    chk({name, "_lo"},   int'(digit_lo), lo);
    chk({name, "_tick"}, int'(tick),     tk);
    chk({name, "_wrap"}, int'(wrap),     wr);
    chk({name, "_err"},  int'(load_err), er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; up = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("reset", 0, 0, 0, 0, 0);

    // Free run: a step every 4th cycle, carry at the 10th.
    reset_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      repeat (P) @(posedge clk);
      #1 chk_out("run", k / 10, k % 10, 1, 0, 0);
    end

    // Load 98 then two steps to the wrap.
    @(negedge clk); load = 1'b1; load_val = 8'h98;
    @(posedge clk); #1 chk_out("ld98", 9, 8, 0, 0, 0);
    @(negedge clk); load = 1'b0;
    repeat (4) @(posedge clk); #1 chk_out("to99", 9, 9, 1, 0, 0);
    repeat (4) @(posedge clk); #1 chk_out("wrap", 0, 0, 1, 1, 0);

    // Non-BCD load in a step cycle: load wins, prescaler restarts.
    repeat (3) @(posedge clk);
    @(negedge clk); load = 1'b1; load_val = 8'h3C;
    @(posedge clk); #1 chk_out("ld3c", 3, 0, 0, 0, 1);
    @(negedge clk); load = 1'b0;
    repeat (3) @(posedge clk); #1 chk_out("ld3c_wait", 3, 0, 0, 0, 0);
    @(posedge clk); #1 chk_out("ld3c_step", 3, 1, 1, 0, 0);

    // en low for 5 cycles after one prescale count: step moves from +4 to +9.
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    repeat (5) @(negedge clk);
    chk_out("hold", 3, 1, 0, 0, 0);
    en = 1'b1;
    @(posedge clk); #1 chk_out("hold7", 3, 1, 0, 0, 0);
    @(posedge clk); #1 chk_out("hold8", 3, 1, 0, 0, 0);
    @(posedge clk); #1 chk_out("hold9", 3, 2, 1, 0, 0);

    // Upper nibble non-BCD.
    @(negedge clk); load = 1'b1; load_val = 8'hA5;
    @(posedge clk); #1 chk_out("lda5", 0, 5, 0, 0, 1);

    // Reset at prescaler=2 with 57 loaded; load/en during reset ignored.
    @(negedge clk); load = 1'b1; load_val = 8'h57;
    @(posedge clk); #1 chk_out("ld57", 5, 7, 0, 0, 0);
    @(negedge clk); load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b0; load = 1'b1; load_val = 8'h33;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_out("in_rst", 0, 0, 0, 0, 0);
    reset_n = 1'b1; load = 1'b0;
    repeat (3) @(posedge clk); #1 chk_out("post_rst3", 0, 0, 0, 0, 0);
    @(posedge clk); #1 chk_out("post_rst4", 0, 1, 1, 0, 0);

`ifdef KLINGON_DOWN_COUNT_EN
    @(negedge clk); load = 1'b1; load_val = 8'h00; up = 1'b0;
    @(posedge clk); #1 chk_out("ld00", 0, 0, 0, 0, 0);
    @(negedge clk); load = 1'b0;
    repeat (4) @(posedge clk); #1 chk_out("dn99", 9, 9, 1, 1, 0);
    repeat (4) @(posedge clk); #1 chk_out("dn98", 9, 8, 1, 0, 0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/klingon_digit_sequencer.md
KLINGON_DIGIT_SEQUENCER -- requirements
Module: klingon_digit_sequencer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 100: clock cycles per count step; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: count enable; the prescaler advances only while high.
REQ-005 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-006 The block SHALL have port load_val, input, 8 bits: [7:4] tens BCD digit, [3:0] units BCD digit.
REQ-007 The block SHALL have port up, input, 1 bit, present only with KLINGON_DOWN_COUNT_EN: 1 = count up, 0 = count down.
REQ-008 The block SHALL have port digit_lo, output, 4 bits: units digit 0..9, feeding one Klingon digit encoder.
REQ-009 The block SHALL have port digit_hi, output, 4 bits: tens digit 0..9, feeding a second encoder.
REQ-010 The block SHALL have port tick, output, 1 bit: one-cycle pulse in the cycle new step values first appear.
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a step crosses 99<->00.
REQ-012 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load carried a non-BCD nibble.

Function
REQ-013 The prescaler SHALL count 0..PRESCALE-1 while en=1, hold while en=0, and return to 0 after PRESCALE-1.
REQ-014 A step SHALL occur on the edge where the prescaler equals PRESCALE-1 and en=1; the new digits and tick SHALL be visible from that edge.
REQ-015 Up step: digit_lo +1; from 9 to 0 with carry into digit_hi +1; 99 -> 00 with wrap=1 in the same cycle as tick.
REQ-016 Down step (macro only): digit_lo -1; from 0 to 9 with borrow from digit_hi; 00 -> 99 with wrap=1.
REQ-017 Load SHALL capture load_val on the edge where load=1, visible next cycle, latency 1, and reset the prescaler to 0.
REQ-018 Load SHALL take priority over a simultaneous step; no tick or wrap SHALL be produced in that cycle.
REQ-019 Any loaded nibble >9 SHALL be stored as 0, other nibble loaded normally, and load_err pulses for one cycle.
REQ-020 Load SHALL act regardless of en.
REQ-021 digit_lo and digit_hi SHALL never hold a value above 9.
REQ-022 All outputs SHALL be driven directly from registers, with no combinational path from any input.
REQ-023 tick, wrap and load_err SHALL be low in every cycle other than the ones specified.

Reset
REQ-024 On reset_n=0, asynchronously: digit_lo=0, digit_hi=0, prescaler=0, tick=0, wrap=0, load_err=0.
REQ-025 Reset asserted mid-count SHALL discard the partial prescaler count; the first step after release SHALL come PRESCALE enabled cycles later.
REQ-026 Load or en active during reset SHALL have no effect.

Configuration
REQ-027 Macro KLINGON_DOWN_COUNT_EN defined: the up port exists and REQ-016 applies; up is sampled on the step edge.
REQ-028 Macro undefined: the up port is absent and the block counts up only; all other behaviour is identical.

Verification
REQ-029 Each scenario below SHALL be covered by a directed bench test:
- PRESCALE=4, reset, en=1 held: tick every 4th cycle; digits 00,01,..,09,10 with the carry at the 10th step.
- Load 8'h98, en=1: after 2 steps digits=00, wrap=1 and tick=1 in the same cycle.
- load=1 with load_val=8'h3C in a step cycle: next cycle digits 3,0; load_err=1; tick=0; prescaler=0.
- en toggled low for 5 cycles mid-prescale: step delayed by exactly 5 cycles; digits unchanged meanwhile.
- Macro on, load 8'h00, up=0: one step -> 99, wrap=1; next step -> 98, wrap=0.
- reset_n pulsed low at prescaler=2 with digits=57: outputs 00 immediately; next tick 4 enabled cycles after release.
